eth_tx_gmii_framer: RTL and testbench

//  Downstream neighbour of eth_tx inside eth_core: consumes the per-frame byte stream that eth_tx

---
 rtl/eth_tx_gmii_framer.sv | 165 ++++++++++++++++
 tb/tb_eth_tx_gmii_framer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_gmii_framer.sv
// rtl/eth_tx_gmii_framer.sv - GMII transmit framer: preamble/SFD, zero pad, CRC-32 FCS, inter-frame gap.
// State names describe what is on gmii_txd in the current cycle; the next byte is loaded at the clock edge.
module eth_tx_gmii_framer #(
  parameter int MIN_FRAME = 60,
  parameter int IFG_BYTES = 12,
  parameter int PRE_LEN   = 7
) (
  input  logic       ACLK,
  input  logic       ARESETn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       frame_done,
  output logic       underrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_ABORT, S_IFG
  } state_t;

  localparam logic [15:0] MIN_W    = 16'(MIN_FRAME);
  localparam logic [7:0]  PRE_LAST = 8'(PRE_LEN - 1);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);

  state_t      state, state_nx;
  logic [7:0]  cnt, cnt_nx;
  logic [15:0] byte_cnt, byte_cnt_nx;
  logic [31:0] crc, crc_nx, crc_inv;
  logic [7:0]  txd_nx;
  logic        en_nx, er_nx, done_nx, und_nx;
  logic [1:0]  fcs_idx;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign crc_inv = ~crc;
  assign fcs_idx = cnt[1:0] + 2'd1;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      byte_cnt   <= '0;
      crc        <= '1;
      gmii_txd   <= '0;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      byte_cnt   <= byte_cnt_nx;
      crc        <= crc_nx;
      gmii_txd   <= txd_nx;
      gmii_tx_en <= en_nx;
      gmii_tx_er <= er_nx;
      frame_done <= done_nx;
      underrun   <= und_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    byte_cnt_nx = byte_cnt;
    crc_nx      = crc;
    txd_nx      = 8'h00;
    en_nx       = 1'b0;
    er_nx       = 1'b0;
    done_nx     = 1'b0;
    und_nx      = 1'b0;
    tx_ready    = 1'b0;
    case (state)
      S_IDLE: begin
        byte_cnt_nx = '0;
        crc_nx      = '1;
        if (tx_valid) begin
          state_nx = S_PRE;
          cnt_nx   = '0;
          txd_nx   = 8'h55;
          en_nx    = 1'b1;
        end
      end
      S_PRE: begin
        en_nx = 1'b1;
        if (cnt == PRE_LAST) begin
          txd_nx   = 8'hD5;
          state_nx = S_SFD;
        end else begin
          txd_nx = 8'h55;
          cnt_nx = cnt + 8'd1;
        end
      end
      S_SFD, S_DATA: begin
        tx_ready = 1'b1;
        en_nx    = 1'b1;
        if (tx_valid) begin
          txd_nx      = tx_data;
          crc_nx      = crc_byte(crc, tx_data);
          byte_cnt_nx = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
          state_nx    = tx_last ? S_PAD : S_DATA;
        end else begin
          er_nx    = 1'b1;
          und_nx   = 1'b1;
          state_nx = S_ABORT;
        end
      end
      // Wire shows the last payload byte (or a pad byte); pad until the minimum is reached.
      S_PAD: begin
        en_nx = 1'b1;
        if (byte_cnt < MIN_W) begin
          crc_nx      = crc_byte(crc, 8'h00);
          byte_cnt_nx = byte_cnt + 16'd1;
        end else begin
          txd_nx   = crc_inv[7:0];
          cnt_nx   = '0;
          state_nx = S_FCS;
        end
      end
      S_FCS: begin
        if (cnt[1:0] == 2'd3) begin
          cnt_nx   = '0;
          state_nx = S_IFG;
        end else begin
          en_nx   = 1'b1;
          txd_nx  = crc_inv[{fcs_idx, 3'b000} +: 8];
          cnt_nx  = cnt + 8'd1;
          done_nx = (fcs_idx == 2'd3);
        end
      end
      S_ABORT: begin
        cnt_nx   = '0;
        state_nx = S_IFG;
      end
      S_IFG: begin
        byte_cnt_nx = '0;
        crc_nx      = '1;
        if (cnt == IFG_LAST) begin
          cnt_nx = '0;
          if (tx_valid) begin
            state_nx = S_PRE;
            txd_nx   = 8'h55;
            en_nx    = 1'b1;
          end else begin
            state_nx = S_IDLE;
          end
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_eth_tx_gmii_framer.sv
// tb/tb_eth_tx_gmii_framer.sv - self-checking bench for eth_tx_gmii_framer.
// A queue of expected GMII beats is built from each frame's payload and checked every cycle.
module tb_eth_tx_gmii_framer;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en, gmii_tx_er, frame_done, underrun;

  logic [7:0] d9_data = 8'h00;
  logic       d9_valid = 1'b0;
  logic       d9_last = 1'b0;
  logic       d9_ready;
  logic [7:0] d9_txd;
  logic       d9_en, d9_er, d9_done, d9_und;

  always #5 aclk = ~aclk;

  eth_tx_gmii_framer dut (
    .ACLK(aclk), .ARESETn(aresetn), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
    .frame_done(frame_done), .underrun(underrun)
  );

  eth_tx_gmii_framer #(.MIN_FRAME(9)) dut9 (
    .ACLK(aclk), .ARESETn(aresetn), .tx_data(d9_data), .tx_valid(d9_valid), .tx_last(d9_last),
    .tx_ready(d9_ready), .gmii_txd(d9_txd), .gmii_tx_en(d9_en), .gmii_tx_er(d9_er),
    .frame_done(d9_done), .underrun(d9_und)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       er;
    logic       done;
    logic       und;
  } beat_t;

  localparam int MIN = 60;

  int    total = 0;
  int    bad = 0;
  beat_t exp_q[$];
  beat_t cur;
  int    idle_run = 0, en_run = 0, last_gap = 0, last_len = 0;
  int    ready_cnt = 0, done_cnt = 0, und_cnt = 0;
  logic [7:0] cap9[$];
  int    d9_done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_crc(input logic [7:0] q[$]);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (q[i])
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ q[i][k];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    return c;
  endfunction

  function automatic void push(input logic [7:0] d, input logic er, input logic done, input logic und);
    exp_q.push_back({d, er, done, und});
  endfunction

  // mode 0: complete frame; mode 1: underrun after stop_n bytes; mode 2: reset mid-frame
  function automatic void push_frame(input logic [7:0] pay[$], input int mode, input int stop_n);
    logic [7:0]  body[$];
    logic [31:0] fcs;
    for (int i = 0; i < 7; i++) push(8'h55, 1'b0, 1'b0, 1'b0);
    push(8'hD5, 1'b0, 1'b0, 1'b0);
    if (mode == 1) begin
      for (int i = 0; i < stop_n; i++) push(pay[i], 1'b0, 1'b0, 1'b0);
      push(8'h00, 1'b1, 1'b0, 1'b1);
    end else begin
      body = pay;
      while (body.size() < MIN) body.push_back(8'h00);
      foreach (body[i]) push(body[i], 1'b0, 1'b0, 1'b0);
      fcs = ~model_crc(body);
      for (int i = 0; i < 4; i++) push(fcs[8*i +: 8], 1'b0, (i == 3), 1'b0);
    end
  endfunction

  always @(negedge aclk) begin
    if (!aresetn) begin
      idle_run = 0;
      en_run   = 0;
    end else begin
      if (tx_ready) ready_cnt++;
      if (frame_done) done_cnt++;
      if (underrun) und_cnt++;
      if (gmii_tx_en) begin
        if (idle_run > 0) last_gap = idle_run;
        idle_run = 0;
        en_run++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got txd=%0h er=%0b want no transmission", gmii_txd, gmii_tx_er);
        end else begin
          cur = exp_q.pop_front();
          check("beat", {gmii_txd, gmii_tx_er, frame_done, underrun}, cur);
        end
      end else begin
        if (en_run > 0) last_len = en_run;
        en_run = 0;
        idle_run++;
        check("idle", {gmii_txd, gmii_tx_er, frame_done, underrun}, 0);
      end
    end
  end

  always @(negedge aclk) begin
    if (aresetn) begin
      if (d9_en) cap9.push_back(d9_txd);
      if (d9_done) d9_done_cnt++;
    end
  end

  task automatic send_frame(input int len, input logic [7:0] seed, input int mode, input int stop_n);
    logic [7:0] pay[$];
    int idx;
    int budget;
    idx = 0;
    budget = 0;
    for (int i = 0; i < len; i++) pay.push_back(seed + 8'(i));
    push_frame(pay, mode, stop_n);
    tx_valid = 1'b1;
    while (idx < len && budget < 400) begin
      if (mode != 0 && idx == stop_n) break;
      tx_data = pay[idx];
      tx_last = (idx == len - 1);
      @(negedge aclk);
      if (tx_ready) idx++;
      @(posedge aclk);
      #1;
      budget++;
    end
    check("send_budget", (budget < 400), 1);
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    if (mode == 1) begin
      @(posedge aclk);
      #1;
    end else if (mode == 2) begin
      #2 aresetn = 1'b0;
      #1;
      check("reset_midframe", {gmii_tx_en, gmii_tx_er, gmii_txd, tx_ready, frame_done, underrun}, 0);
      exp_q.delete();
      repeat (3) @(posedge aclk);
      #3 aresetn = 1'b1;
    end
  endtask

  task automatic wait_drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 1000) begin
      @(posedge aclk);
      b++;
    end
    check("drain", exp_q.size(), 0);
    repeat (3) @(posedge aclk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp9 [21];
    logic [7:0] ascii[$];
    int idx, b, d0, u0, r0;
    exp9 = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5,
             8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
             8'h26, 8'h39, 8'hF4, 8'hCB};

    repeat (3) @(posedge aclk);
    #1;
    check("reset_out", {gmii_tx_en, gmii_tx_er, gmii_txd, tx_ready, frame_done, underrun}, 0);
    check("reset_out9", {d9_en, d9_er, d9_txd, d9_ready, d9_done, d9_und}, 0);
    aresetn = 1'b1;

    for (int i = 0; i < 9; i++) ascii.push_back(8'h31 + 8'(i));
    check("model_crc_check", model_crc(ascii), 32'h340BC6D9);

    // MIN_FRAME=9 instance: "123456789" needs no pad; FCS is the CRC-32 check value
    d9_valid = 1'b1;
    idx = 0;
    b = 0;
    while (idx < 9 && b < 100) begin
      d9_data = 8'h31 + 8'(idx);
      d9_last = (idx == 8);
      @(negedge aclk);
      if (d9_ready) idx++;
      @(posedge aclk);
      #1;
      b++;
    end
    d9_valid = 1'b0;
    d9_last  = 1'b0;
    repeat (30) @(posedge aclk);
    #1;
    check("min9_len", cap9.size(), 21);
    for (int i = 0; i < 21; i++)
      if (i < cap9.size()) check("min9_byte", cap9[i], exp9[i]);
    check("min9_done", d9_done_cnt, 1);

    // short frame padded to 60
    d0 = done_cnt;
    send_frame(10, 8'h01, 0, 0);
    wait_drain();
    check("short_len", last_len, 72);
    check("short_done", done_cnt - d0, 1);

    // back-to-back 64-byte frames with tx_valid held high
    d0 = done_cnt;
    send_frame(64, 8'h40, 0, 0);
    send_frame(64, 8'hC0, 0, 0);
    wait_drain();
    check("b2b_gap", last_gap, 12);
    check("b2b_len", last_len, 76);
    check("b2b_done", done_cnt - d0, 2);

    // underrun after 20 bytes, then a clean frame right behind it
    d0 = done_cnt;
    u0 = und_cnt;
    send_frame(30, 8'h10, 1, 20);
    send_frame(16, 8'h20, 0, 0);
    wait_drain();
    check("underrun_gap", last_gap, 12);
    check("underrun_pulses", und_cnt - u0, 1);
    check("underrun_done", done_cnt - d0, 1);
    check("after_underrun_len", last_len, 72);

    // reset at byte 30 of a 100-byte frame, then a clean frame
    send_frame(100, 8'h30, 2, 30);
    d0 = done_cnt;
    send_frame(40, 8'h50, 0, 0);
    wait_drain();
    check("post_reset_done", done_cnt - d0, 1);
    check("post_reset_len", last_len, 72);

    // 1-byte frame
    d0 = done_cnt;
    r0 = ready_cnt;
    send_frame(1, 8'hAB, 0, 0);
    wait_drain();
    check("one_byte_ready", ready_cnt - r0, 1);
    check("one_byte_done", done_cnt - d0, 1);
    check("one_byte_len", last_len, 72);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
